// File: rtl/timer_param_bank_pkg.sv
// Shared traffic-light definitions: countdown FSM states and the default
// phase durations used to build the reset/restore image of the param bank.
package timer_param_bank_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } timer_state_t;

   // Default phase durations (ticks). Index 0 sits in the LSBs of DEF_PARAMS.
   localparam logic [3:0] DEF_GREEN  = 4'd6;
   localparam logic [3:0] DEF_WALK   = 4'd3;
   localparam logic [3:0] DEF_YELLOW = 4'd2;

   localparam logic [11:0] DEF_PARAMS = {DEF_YELLOW, DEF_WALK, DEF_GREEN};

endpackage

// File: rtl/timer_param_regs.sv
// Param register file for the traffic-light timer.
// Holds NUM_PARAMS durations, handles restore-all / single writes / rejected
// writes, and presents the selected (optionally doubled) duration.
// Ports:
//   clk, reset     - clock, synchronous active-high reset
//   prog_sync      - programming strobe (one write per asserted cycle)
//   selector       - 0 = restore defaults, k = write param k-1
//   time_value     - write data (0 is rejected)
//   interval       - index of the duration presented on value
//   double_en      - present twice the selected duration
//   value          - combinational selected duration, WIDTH+1 bits
//   prog_err       - registered one-cycle pulse on a rejected write
module timer_param_regs
   import timer_param_bank_pkg::*;
#(
   parameter int WIDTH      = 4,
   parameter int NUM_PARAMS = 3,
   parameter logic [NUM_PARAMS*WIDTH-1:0] DEFAULTS = DEF_PARAMS,
   parameter int SEL_W      = $clog2(NUM_PARAMS + 1),
   parameter int IDX_W      = (NUM_PARAMS > 1) ? $clog2(NUM_PARAMS) : 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             prog_sync,
   input  logic [SEL_W-1:0] selector,
   input  logic [WIDTH-1:0] time_value,
   input  logic [IDX_W-1:0] interval,
   input  logic             double_en,
   output logic [WIDTH:0]   value,
   output logic             prog_err
);

   logic [WIDTH-1:0]      param_reg [NUM_PARAMS];
   logic [NUM_PARAMS-1:0] wr_hit;
   logic                  restore;
   logic                  wr_reject;
   logic                  prog_err_reg;
   logic [WIDTH-1:0]      sel_param;

   assign restore   = prog_sync && (selector == '0);
   // Out-of-range selector or a zero duration is refused; a zero-length
   // interval would make the countdown meaningless.
   assign wr_reject = prog_sync && (selector != '0) &&
                      ((selector > SEL_W'(NUM_PARAMS)) || (time_value == '0));

   genvar gi;
   generate
      for (gi = 0; gi < NUM_PARAMS; gi++) begin : g_wr
         assign wr_hit[gi] = prog_sync && (selector == SEL_W'(gi + 1)) &&
                             (time_value != '0);
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (reset || restore) begin
         for (int i = 0; i < NUM_PARAMS; i++) begin
            param_reg[i] <= DEFAULTS[i*WIDTH +: WIDTH];
         end
      end else begin
         for (int i = 0; i < NUM_PARAMS; i++) begin
            if (wr_hit[i]) begin
               param_reg[i] <= time_value;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         prog_err_reg <= 1'b0;
      end else begin
         prog_err_reg <= wr_reject;
      end
   end

   // Indices past the last param fall back to param 0.
   always_comb begin
      sel_param = param_reg[0];
      for (int i = 1; i < NUM_PARAMS; i++) begin
         if (interval == IDX_W'(i)) begin
            sel_param = param_reg[i];
         end
      end
   end

   assign value    = double_en ? {sel_param, 1'b0} : {1'b0, sel_param};
   assign prog_err = prog_err_reg;

endmodule

// File: rtl/timer_param_bank.sv
// Programmable interval store plus tick-driven countdown for the traffic
// light controller. The param bank supplies value; the FSM loads it on
// start_timer and counts down on tick, pulsing expired when it reaches 0.
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   prog_sync, selector, time_value - programming interface
//   interval, double_en - duration select / doubling
//   tick                - countdown enable strobe
//   start_timer         - load and start request (ignored while running)
//   value               - combinational selected duration
//   count               - remaining ticks
//   busy                - countdown running
//   expired             - one-cycle pulse when count reaches 0
//   prog_err            - one-cycle pulse on a rejected write
module timer_param_bank
   import timer_param_bank_pkg::*;
#(
   parameter int WIDTH      = 4,
   parameter int NUM_PARAMS = 3,
   parameter logic [NUM_PARAMS*WIDTH-1:0] DEFAULTS = DEF_PARAMS,
   parameter int SEL_W      = $clog2(NUM_PARAMS + 1),
   parameter int IDX_W      = (NUM_PARAMS > 1) ? $clog2(NUM_PARAMS) : 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             prog_sync,
   input  logic [SEL_W-1:0] selector,
   input  logic [WIDTH-1:0] time_value,
   input  logic [IDX_W-1:0] interval,
   input  logic             double_en,
   input  logic             tick,
   input  logic             start_timer,
   output logic [WIDTH:0]   value,
   output logic [WIDTH:0]   count,
   output logic             busy,
   output logic             expired,
   output logic             prog_err
);

   localparam logic [WIDTH:0] ONE = {{WIDTH{1'b0}}, 1'b1};

   timer_state_t   state_reg;
   logic [WIDTH:0] count_reg;
   logic           busy_reg;
   logic           expired_reg;

   timer_param_regs #(
      .WIDTH      (WIDTH),
      .NUM_PARAMS (NUM_PARAMS),
      .DEFAULTS   (DEFAULTS),
      .SEL_W      (SEL_W),
      .IDX_W      (IDX_W)
   ) u_regs (
      .clk        (clk),
      .reset      (reset),
      .prog_sync  (prog_sync),
      .selector   (selector),
      .time_value (time_value),
      .interval   (interval),
      .double_en  (double_en),
      .value      (value),
      .prog_err   (prog_err)
   );

   // Writes to the bank never touch count_reg: a running interval keeps
   // the value captured at load time.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg   <= IDLE;
         count_reg   <= '0;
         busy_reg    <= 1'b0;
         expired_reg <= 1'b0;
      end else begin
         expired_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (start_timer) begin
                  count_reg <= value;
                  busy_reg  <= 1'b1;
                  state_reg <= RUN;
               end
            end
            RUN: begin
               if (tick) begin
                  if (count_reg == ONE) begin
                     count_reg   <= '0;
                     expired_reg <= 1'b1;
                     busy_reg    <= 1'b0;
                     state_reg   <= IDLE;
                  end else begin
                     count_reg <= count_reg - ONE;
                  end
               end
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

   assign count   = count_reg;
   assign busy    = busy_reg;
   assign expired = expired_reg;

endmodule

// File: tb/tb_timer_param_bank.sv
module tb_timer_param_bank;

   localparam int WIDTH      = 4;
   localparam int NUM_PARAMS = 3;
   localparam int SEL_W      = 2;
   localparam int IDX_W      = 2;

   logic             clk = 1'b0;
   logic             reset;
   logic             prog_sync;
   logic [SEL_W-1:0] selector;
   logic [WIDTH-1:0] time_value;
   logic [IDX_W-1:0] interval;
   logic             double_en;
   logic             tick;
   logic             start_timer;
   logic [WIDTH:0]   value, count;
   logic             busy, expired, prog_err;
   logic [WIDTH:0]   value2, count2;
   logic             busy2, expired2, prog_err2;

   timer_param_bank u_dut (
      .clk         (clk),
      .reset       (reset),
      .prog_sync   (prog_sync),
      .selector    (selector),
      .time_value  (time_value),
      .interval    (interval),
      .double_en   (double_en),
      .tick        (tick),
      .start_timer (start_timer),
      .value       (value),
      .count       (count),
      .busy        (busy),
      .expired     (expired),
      .prog_err    (prog_err)
   );

   // Two-param build: selector 3 is out of range here.
   timer_param_bank #(
      .WIDTH      (4),
      .NUM_PARAMS (2),
      .DEFAULTS   (8'h36)
   ) u_dut2 (
      .clk         (clk),
      .reset       (reset),
      .prog_sync   (prog_sync),
      .selector    (selector),
      .time_value  (time_value),
      .interval    (interval[0]),
      .double_en   (double_en),
      .tick        (tick),
      .start_timer (start_timer),
      .value       (value2),
      .count       (count2),
      .busy        (busy2),
      .expired     (expired2),
      .prog_err    (prog_err2)
   );

   always #5 clk = ~clk;

   int edge_n = 0;
   always @(posedge clk) edge_n <= edge_n + 1;

   int err_cnt = 0;
   int chk_cnt = 0;
   int tick_period = 0;
   int last_e0 = 0;
   int mon_e;
   int exp_q[$];   // expected edge index of each expiry pulse

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      chk_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, edge_n);
      end
   endtask

   // Edge on which the v-th tick after e0 lands, ticks on edges divisible by p.
   function automatic int exp_edge(input int e0, input int v, input int p);
      int e = e0;
      int c = 0;
      while (c < v) begin
         e++;
         if (e % p == 0) c++;
      end
      return e;
   endfunction

   function automatic int ticks_in(input int e0, input int e1, input int p);
      int c = 0;
      for (int e = e0 + 1; e <= e1; e++) begin
         if (e % p == 0) c++;
      end
      return c;
   endfunction

   // Scoreboard side: every expiry pulse must match a queued expectation.
   always @(negedge clk) begin
      if (expired) begin
         if (exp_q.size() == 0) begin
            check("unexpected_expired", {31'd0, expired}, 32'd0);
         end else begin
            mon_e = exp_q.pop_front();
            check("expire_edge", edge_n, mon_e);
            check("expire_count", {27'd0, count}, 32'd0);
            check("expire_busy", {31'd0, busy}, 32'd0);
         end
         $display("expired at edge %0d count=%0d busy=%0d", edge_n, count, busy);
      end
   end

   task automatic step();
      tick = (tick_period != 0) && (((edge_n + 1) % tick_period) == 0);
      @(posedge clk);
      #1;
   endtask

   task automatic chk_value(input logic [IDX_W-1:0] idx, input logic dbl,
                            input int expv, input string tag);
      interval  = idx;
      double_en = dbl;
      #1;
      check(tag, {27'd0, value}, expv);
      $display("value idx=%0d dbl=%0d -> %0d", idx, dbl, value);
   endtask

   task automatic prog(input logic [SEL_W-1:0] sel, input logic [WIDTH-1:0] tv);
      prog_sync  = 1'b1;
      selector   = sel;
      time_value = tv;
      step();
      prog_sync  = 1'b0;
      $display("prog sel=%0d tv=%0d prog_err=%0d prog_err2=%0d", sel, tv, prog_err, prog_err2);
   endtask

   task automatic start_run(input logic [IDX_W-1:0] idx, input int v, input bit push);
      interval    = idx;
      start_timer = 1'b1;
      last_e0     = edge_n + 1;
      if (push) exp_q.push_back(exp_edge(last_e0, v, tick_period));
      step();
      start_timer = 1'b0;
      check("start_count", {27'd0, count}, v);
      check("start_busy", {31'd0, busy}, 32'd1);
      $display("start idx=%0d at edge %0d count=%0d", idx, last_e0, count);
   endtask

   task automatic wait_done(input int budget);
      int n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         step();
         n++;
      end
      if (exp_q.size() != 0) begin
         check("expire_timeout", exp_q.size(), 32'd0);
         exp_q.delete();
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      reset       = 1'b1;
      prog_sync   = 1'b0;
      selector    = '0;
      time_value  = '0;
      interval    = '0;
      double_en   = 1'b0;
      tick        = 1'b0;
      start_timer = 1'b0;
      repeat (3) step();
      check("rst_count", {27'd0, count}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_expired", {31'd0, expired}, 32'd0);
      check("rst_prog_err", {31'd0, prog_err}, 32'd0);
      reset = 1'b0;
      step();

      // Default durations and doubling.
      chk_value(0, 1'b0, 6, "val_i0");
      chk_value(1, 1'b0, 3, "val_i1");
      chk_value(2, 1'b0, 2, "val_i2");
      chk_value(0, 1'b1, 12, "val_i0_dbl");
      chk_value(2, 1'b1, 4, "val_i2_dbl");
      chk_value(3, 1'b0, 6, "val_i3_oob");
      interval = 1; double_en = 1'b0; #1;
      check("val2_i1", {27'd0, value2}, 32'd3);

      // Write param 0 = 9, run with a tick every cycle.
      prog(1, 9);
      check("prog_ok_err", {31'd0, prog_err}, 32'd0);
      chk_value(0, 1'b0, 9, "val_after_wr");
      tick_period = 1;
      start_run(0, 9, 1'b1);
      wait_done(40);
      check("done_busy", {31'd0, busy}, 32'd0);
      check("done_count", {27'd0, count}, 32'd0);

      // Tick every 4th cycle, V=3, with an ignored mid-run start.
      tick_period = 4;
      start_run(1, 3, 1'b1);
      repeat (3) step();
      interval    = 0;
      start_timer = 1'b1;
      step();
      start_timer = 1'b0;
      check("ignored_start_count", {27'd0, count}, 3 - ticks_in(last_e0, edge_n, 4));
      check("ignored_start_busy", {31'd0, busy}, 32'd1);
      wait_done(40);

      // Rejected writes.
      tick_period = 0;
      prog(3, 0);
      check("err_zero_pulse", {31'd0, prog_err}, 32'd1);
      step();
      check("err_zero_clear", {31'd0, prog_err}, 32'd0);
      chk_value(2, 1'b0, 2, "val_i2_kept");
      prog(3, 5);
      check("err_oob_pulse2", {31'd0, prog_err2}, 32'd1);
      check("ok_sel3_err", {31'd0, prog_err}, 32'd0);
      chk_value(2, 1'b0, 5, "val_i2_wr");

      // Mid-run write leaves the running count alone.
      tick_period = 2;
      start_run(0, 9, 1'b1);
      repeat (2) step();
      prog(1, 5);
      check("midrun_count", {27'd0, count}, 9 - ticks_in(last_e0, edge_n, 2));
      wait_done(60);

      // New value is loaded next; restore-all during the run.
      tick_period = 0;
      start_run(0, 5, 1'b0);
      prog(0, 0);
      check("restore_err", {31'd0, prog_err}, 32'd0);
      check("restore_count_held", {27'd0, count}, 32'd5);
      chk_value(0, 1'b0, 6, "restore_i0");
      chk_value(1, 1'b0, 3, "restore_i1");
      chk_value(2, 1'b0, 2, "restore_i2");
      tick_period = 1;
      exp_q.push_back(exp_edge(edge_n, 5, 1));
      wait_done(40);

      // Reset in the middle of a run aborts without an expiry pulse.
      prog(2, 7);
      chk_value(1, 1'b0, 7, "val_i1_wr7");
      start_run(0, 6, 1'b0);
      repeat (4) step();
      check("pre_reset_count", {27'd0, count}, 32'd2);
      reset = 1'b1;
      step();
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_count", {27'd0, count}, 32'd0);
      check("abort_expired", {31'd0, expired}, 32'd0);
      reset = 1'b0;
      chk_value(1, 1'b0, 3, "abort_i1_default");
      chk_value(0, 1'b0, 6, "abort_i0_default");
      repeat (10) step();
      check("sb_empty", exp_q.size(), 32'd0);

      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

endmodule
